// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: core states,
// opcodes and default widths, plus a helper that folds illegal requests.
package pc_sequencer_pkg;

    // Default program-counter width used by every block that addresses
    // instruction memory.
    localparam int PC_WIDTH_DEFAULT    = 16;

    // Default width of the brace-nesting depth counter.
    localparam int DEPTH_WIDTH_DEFAULT = 8;

    // Sequencer states. HALT_S is terminal until reset.
    typedef enum logic [1:0] {
        CORE_S   = 2'd0,
        BRANCH_S = 2'd1,
        STALL_S  = 2'd2,
        HALT_S   = 2'd3
    } core_state;

    // Instruction opcodes. CBF opens a conditional block, CBB closes it.
    typedef enum logic [3:0] {
        NOP = 4'd0,
        INC = 4'd1,
        DEC = 4'd2,
        LFT = 4'd3,
        RGT = 4'd4,
        OUT = 4'd5,
        INP = 4'd6,
        CBF = 4'd7,
        CBB = 4'd8,
        PSH = 4'd9,
        POP = 4'd10,
        HLT = 4'd11
    } op_code;

    // Core control may only request CORE_S, BRANCH_S or STALL_S; anything
    // else (i.e. HALT_S) is folded back to CORE_S. Halting goes through the
    // dedicated halt input only.
    function automatic core_state legal_next_state(input core_state req);
        core_state res;
        res = CORE_S;
        if ((req == BRANCH_S) || (req == STALL_S)) begin
            res = req;
        end
        return res;
    endfunction

endpackage

// File: rtl/pc_sequencer_brace_depth_counter.sv
// Brace-nesting depth counter. Load-to-one starts a forward skip, inc/dec
// track nested CBF/CBB pairs. The counter saturates: increments at the
// maximum are refused and the owner reports the overflow.
module brace_depth_counter
    import pc_sequencer_pkg::*;
#(
    parameter int DEPTH_WIDTH = DEPTH_WIDTH_DEFAULT
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_load_one,
    input  logic                   i_inc,
    input  logic                   i_dec,
    output logic [DEPTH_WIDTH-1:0] o_depth,
    output logic                   o_at_one,
    output logic                   o_at_max
);

    logic [DEPTH_WIDTH-1:0] r_depth;
    logic                   w_at_zero;

    assign w_at_zero = (r_depth == '0);
    assign o_at_one  = (r_depth == DEPTH_WIDTH'(1));
    assign o_at_max  = &r_depth;
    assign o_depth   = r_depth;

    // Depth register: load-to-one wins over inc, inc over dec; never wraps.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_depth <= '0;
        end else if (i_load_one) begin
            r_depth <= DEPTH_WIDTH'(1);
        end else if (i_inc && !o_at_max) begin
            r_depth <= r_depth + DEPTH_WIDTH'(1);
        end else if (i_dec && !w_at_zero) begin
            r_depth <= r_depth - DEPTH_WIDTH'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer. Owns the pc and the sequencer state; in
// CORE_S it follows core control, in BRANCH_S it scans forward over a
// skipped CBF..CBB body by itself, STALL_S is a one-cycle bubble, and
// HALT_S freezes everything until reset.
//
// Handshake: there is no valid/ready pair. Core control outputs
// (next_state, pc_write, halt, pc_load) are qualified by o_core_enable:
// they are consumed on a rising edge only while o_core_enable is high
// (pc_load is additionally consumed in STALL_S) and ignored otherwise.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int PC_WIDTH    = PC_WIDTH_DEFAULT,
    parameter int DEPTH_WIDTH = DEPTH_WIDTH_DEFAULT
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  op_code                 i_instruction,
    input  core_state              i_next_state,
    input  logic                   i_pc_write,
    input  logic                   i_halt,
    input  logic                   i_pc_load,
    input  logic [PC_WIDTH-1:0]    i_pc_load_value,
    output logic [PC_WIDTH-1:0]    o_pc,
    output core_state              o_state,
    output logic                   o_core_enable,
    output logic                   o_halted,
    output logic                   o_depth_error,
    output logic [DEPTH_WIDTH-1:0] o_depth
);

    core_state             r_state;
    logic [PC_WIDTH-1:0]   r_pc;
    logic                  r_depth_error;

    core_state             w_next_legal;
    logic [PC_WIDTH-1:0]   w_pc_inc;
    logic                  w_is_cbf;
    logic                  w_is_cbb;
    logic                  w_load_one;
    logic                  w_inc;
    logic                  w_dec;
    logic                  w_at_one;
    logic                  w_at_max;

    // Requested next state with illegal encodings folded to CORE_S.
    assign w_next_legal = legal_next_state(i_next_state);

    // pc + 1 modulo 2^PC_WIDTH; the carry out is simply dropped.
    assign w_pc_inc = r_pc + PC_WIDTH'(1);

    // Opcode decode is only meaningful while scanning a skipped body.
    assign w_is_cbf = (r_state == BRANCH_S) && (i_instruction == CBF);
    assign w_is_cbb = (r_state == BRANCH_S) && (i_instruction == CBB);

    // Entering a skip sets depth to one on the same edge as the state change.
    assign w_load_one = (r_state == CORE_S) && !i_halt && (w_next_legal == BRANCH_S);
    assign w_inc      = w_is_cbf && !w_at_max;
    assign w_dec      = w_is_cbb;

    brace_depth_counter #(
        .DEPTH_WIDTH(DEPTH_WIDTH)
    ) u_depth (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_load_one (w_load_one),
        .i_inc      (w_inc),
        .i_dec      (w_dec),
        .o_depth    (o_depth),
        .o_at_one   (w_at_one),
        .o_at_max   (w_at_max)
    );

    // Sequencer FSM: state, pc and the sticky overflow flag.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= CORE_S;
            r_pc          <= '0;
            r_depth_error <= 1'b0;
        end else begin
            case (r_state)
                CORE_S: begin
                    // halt outranks every other request and freezes pc.
                    if (i_halt) begin
                        r_state <= HALT_S;
                    end else begin
                        if (i_pc_load) begin
                            r_pc <= i_pc_load_value;
                        end else if (i_pc_write) begin
                            r_pc <= w_pc_inc;
                        end
                        r_state <= w_next_legal;
                    end
                end
                STALL_S: begin
                    // Single bubble; only pc_load is honoured here.
                    if (i_pc_load) begin
                        r_pc <= i_pc_load_value;
                    end else begin
                        r_pc <= w_pc_inc;
                    end
                    r_state <= CORE_S;
                end
                BRANCH_S: begin
                    // Scan forward one instruction per cycle regardless of
                    // core control, so an HLT inside the body is skipped.
                    r_pc <= w_pc_inc;
                    if (w_is_cbf && w_at_max) begin
                        r_depth_error <= 1'b1;
                        r_state       <= HALT_S;
                    end else if (w_is_cbb && w_at_one) begin
                        // Matching CBB: next CORE_S fetch is its address + 1.
                        r_state <= CORE_S;
                    end
                end
                HALT_S: begin
                    r_state <= HALT_S;
                end
                default: begin
                    r_state <= CORE_S;
                end
            endcase
        end
    end

    assign o_pc          = r_pc;
    assign o_state       = r_state;
    assign o_depth_error = r_depth_error;

    // Status decoded straight from the state register.
    assign o_core_enable = (r_state == CORE_S);
    assign o_halted      = (r_state == HALT_S);

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_WIDTH, default 16, width of the program counter.
REQ-002 Parameter DEPTH_WIDTH, default 8, width of the brace-nesting depth counter.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 instruction  input  op_code  opcode currently fetched at pc.
REQ-006 next_state  input  core_state  state requested by core control for the following cycle.
REQ-007 pc_write  input  1  core control permits pc increment this cycle.
REQ-008 halt  input  1  core control decoded HLT.
REQ-009 pc_load  input  1  load pc_load_value instead of incrementing (cached-branch return).
REQ-010 pc_load_value  input  PC_WIDTH  target pc for pc_load.
REQ-011 pc  output  PC_WIDTH  instruction memory address.
REQ-012 state  output  core_state  current sequencer state.
REQ-013 core_enable  output  1  high only in CORE_S; core control outputs are honoured only while high.
REQ-014 halted  output  1  high in HALT_S.
REQ-015 depth_error  output  1  sticky; nesting depth overflowed.

Function
REQ-016 States: CORE_S, BRANCH_S, STALL_S, HALT_S; state, pc, depth and depth_error are registered, and every other output is decoded combinationally from state.
REQ-017 CORE_S: with halt=1, go to HALT_S and hold pc; halt takes priority over pc_load, pc_write and next_state.
REQ-018 CORE_S, halt=0: pc <= pc_load_value if pc_load, else pc+1 if pc_write, else pc is held; state <= next_state.
REQ-019 CORE_S with next_state=BRANCH_S: depth <= 1 on the same edge.
REQ-020 STALL_S: lasts exactly one cycle; pc <= pc_load_value if pc_load, else pc+1; then return to CORE_S; pc_write, halt and next_state are ignored.
REQ-021 BRANCH_S, each cycle, examine instruction at pc and set pc <= pc+1:
  - CBF: depth+1.
  - CBB with depth>1: depth-1.
  - CBB with depth==1: depth <= 0 and state <= CORE_S, so the first CORE_S fetch is the matching CBB address+1.
  - any other opcode: depth unchanged.
REQ-022 BRANCH_S: halt, pc_load, pc_write and next_state are ignored, so HLT inside a skipped body does not halt.
REQ-023 Depth overflow: a CBF in BRANCH_S with depth at 2^DEPTH_WIDTH-1 sets depth_error=1, holds depth and goes to HALT_S.
REQ-024 pc arithmetic is modulo 2^PC_WIDTH; increment from all-ones wraps to 0 without error.
REQ-025 HALT_S is terminal until reset: pc, depth and depth_error are held and all inputs are ignored.
REQ-026 next_state values other than CORE_S, BRANCH_S or STALL_S are treated as CORE_S.

Reset
REQ-027 Reset asserted: state=CORE_S, pc=0, depth=0, depth_error=0, core_enable=1, halted=0, taking effect immediately and independent of clock.
REQ-028 Reset asserted mid-BRANCH_S or mid-STALL_S abandons the operation, leaving no residual depth or pending pc load.
REQ-029 Reset deassertion takes effect on the first rising clock edge after release; pc=0 is the first fetch.

Structure
REQ-030 The core_state enum (with HALT_S added), op_code and a PC_WIDTH constant live in the shared definitions package; this module declares no private copies.
REQ-031 Nesting logic is a sub-module brace_depth_counter (load-1, inc, dec, at_one, at_max); state and pc registers stay in pc_sequencer.

Verification
REQ-032 Program INC,INC,HLT, reset released -> pc 0,1,2, then halted=1 with pc stuck at 2 for 10 cycles.
REQ-033 CBF at pc 4 with acc zero, body CBF,INC,CBB,DEC,CBB at pc 5..9 -> BRANCH_S for 5 cycles, depth 1,2,2,1,1,0, CORE_S fetch at pc 10, core_enable low throughout the scan.
REQ-034 STALL_S from POP at pc 3 -> core_enable low for 1 cycle, next fetch at pc 4; same case with pc_load=1, pc_load_value=0x20 in the stall cycle -> next fetch at pc 0x20.
REQ-035 DEPTH_WIDTH=2 with four nested CBF while in BRANCH_S -> depth_error=1, halted=1 on the overflowing cycle, depth held at 3.
REQ-036 pc=0xFFFF with pc_write=1 -> pc=0x0000 and no error; halt=1 with pc_load=1 in the same cycle -> HALT_S, pc unchanged.
REQ-037 Reset pulsed asynchronously between edges at depth 2 in BRANCH_S -> outputs at reset values before the next edge; after release, first fetch at pc 0 in CORE_S.
